ee201_numlock_ctrl: RTL and testbench
=====================================

Name: ee201_numlock_ctrl

Overview:
- Supervisory controller that sits between the push-button inputs and the ee201 number-lock state machine.
- Gates and arbitrates the U/Z button levels into the lock.
- Generates the lock's Timerout pulse while the lock is in the Opening state.
- Counts failed attempts, enforces a lockout window after too many failures, and clears a stalled entry after inactivity.

Parameters:
- OPEN_CYCLES, 5: cycles the lock stays in Opening before Timerout pulses.
- IDLE_TO, 1000: consecutive idle cycles, with the lock not in I, before lock_clr pulses.
- MAX_FAILS, 3: Bad entries that trigger lockout; range 1..(2^FAIL_W - 1).
- LOCKOUT_CYCLES, 2000: base lockout length in cycles.
- CNT_W, 16: width of the shared down/up counter; must hold max(IDLE_TO, 8*LOCKOUT_CYCLES).
- FAIL_W, 2: width of fail_cnt.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- U_in  in  1  synchronized, debounced U button level.
- Z_in  in  1  synchronized, debounced Z button level.
- q_I  in  1  lock one-hot status: Initial.
- q_Opening  in  1  lock one-hot status: Opening.
- q_Bad  in  1  lock one-hot status: Bad.
- U  out  1  gated U level driven to the lock.
- Z  out  1  gated Z level driven to the lock.
- Timerout  out  1  one-cycle pulse to the lock that ends Opening.
- lock_clr  out  1  one-cycle pulse that forces the lock back to I (lock reset OR-input).
- Lockout  out  1  high for the whole lockout window.
- fail_cnt  out  FAIL_W  failed-attempt count.

Behaviour:
- Reset: while reset=0, state=S_ARM and counter=0. All outputs are 0, fail_cnt=0, and the edge-detect registers are 0.
- Edge detection:
  - The q_Opening and q_Bad inputs are registered.
  - open_rise = q_Opening & ~q_Opening_d.
  - bad_rise = q_Bad & ~q_Bad_d.
- Outputs: all outputs are registered. U and Z have one cycle of latency from U_in and Z_in.
- FSM states: S_ARM, S_CONFLICT, S_OPEN, S_LOCKOUT.
- S_ARM:
  - U <= U_in & ~Z_in; Z <= Z_in & ~U_in.
  - If U_in=Z_in=1: go to S_CONFLICT, and U and Z are 0 on the next cycle.
  - Inactivity counter:
    - Increments while q_I=0 and U_in=Z_in=0.
    - Clears on any button activity or when q_I=1.
    - On reaching IDLE_TO-1: lock_clr=1 for one cycle and the counter clears.
- S_CONFLICT:
  - U=Z=0.
  - Return to S_ARM only when U_in=Z_in=0 (both buttons released). Releasing only one button does not return.
- S_OPEN:
  - Entered on open_rise from any non-lockout state.
  - On entry: fail_cnt <= 0, counter <= 0, U=Z=0.
  - The counter increments each cycle. At count OPEN_CYCLES-1, Timerout=1 for exactly one cycle and the FSM goes to S_ARM.
  - If q_Opening drops early, go to S_ARM without a Timerout pulse.
- Failure handling:
  - On bad_rise (in S_ARM or S_CONFLICT), fail_cnt increments, saturating at 2^FAIL_W-1.
  - If the incremented value is >= MAX_FAILS: go to S_LOCKOUT, counter <= 0, Lockout=1 starting the next cycle.
- S_LOCKOUT:
  - U=Z=0 regardless of buttons. Lockout=1.
  - Counter increments. At LOCKOUT_CYCLES-1 (or the scaled value, see Optional Feature): fail_cnt <= 0, lock_clr=1 for one cycle, Lockout=0, go to S_ARM.
  - If U_in or Z_in is still held at exit, go to S_CONFLICT-style wait instead: U/Z stay 0 until both are released.
- Priority when events coincide in the same cycle: open_rise > bad_rise > conflict > inactivity timeout.
- Pulse widths: lock_clr and Timerout never assert for more than one cycle and never assert in the same cycle.
- Reset mid-operation (including during lockout or opening): everything returns to reset values immediately. No pulse is emitted on reset release.

Optional Feature:
- Macro: NUMLOCK_BACKOFF_EN.
- Defined:
  - A 2-bit lockout_level register (reset 0) scales the lockout length to LOCKOUT_CYCLES << lockout_level.
  - lockout_level increments, saturating at 3 (8x), on each lockout exit.
  - lockout_level clears on open_rise.
- Undefined: every lockout lasts exactly LOCKOUT_CYCLES and no lockout_level register exists.

Test Plan:
- Correct entry: press sequence U, Z, U, U, each press separated by all-released cycles, with the lock model reaching Opening. Required response: Timerout pulses exactly 5 cycles after q_Opening rises, fail_cnt=0, no lock_clr.
- Simultaneous press: assert U_in=Z_in=1 for 3 cycles, release Z_in, hold U_in 2 cycles, then release both. Required response: U=Z=0 throughout; U passes again only after both are released.
- Lockout: three bad_rise events (MAX_FAILS=3). Required response: fail_cnt counts 1, 2, then Lockout=1 for 2000 cycles with button presses ignored; then a single lock_clr pulse and fail_cnt=0.
- Inactivity: q_I=0 with no buttons for 1000 cycles. Required response: lock_clr pulses once at cycle 1000. A press at cycle 999 prevents the pulse and restarts the count.
- Async reset mid-lockout: drop reset at lockout cycle 500. Required response: Lockout=0, fail_cnt=0, outputs 0 the same instant; after release, U follows U_in with 1-cycle latency.
- Backoff (NUMLOCK_BACKOFF_EN defined): two consecutive lockouts. Required response: they last 2000 then 4000 cycles; an intervening open_rise resets the next lockout to 2000.

Source files
------------

// File: rtl/ee201_numlock_ctrl_if.sv
// ee201_numlock_ctrl_if: button, lock-status and lock-control signals of the number-lock supervisor
// Ports (master = supervisor side):
//   U_in, Z_in              debounced button levels in
//   q_I, q_Opening, q_Bad   lock one-hot status in
//   U, Z                    gated button levels out to the lock
//   Timerout                one-cycle pulse that ends Opening
//   lock_clr                one-cycle pulse that forces the lock back to I
//   Lockout                 high for the whole lockout window
//   fail_cnt                failed-attempt count
interface ee201_numlock_ctrl_if #(
    parameter int FAIL_W = 2
);
    logic              U_in;
    logic              Z_in;
    logic              q_I;
    logic              q_Opening;
    logic              q_Bad;
    logic              U;
    logic              Z;
    logic              Timerout;
    logic              lock_clr;
    logic              Lockout;
    logic [FAIL_W-1:0] fail_cnt;
    modport master (
        input  U_in, Z_in, q_I, q_Opening, q_Bad,
        output U, Z, Timerout, lock_clr, Lockout, fail_cnt
    );
    modport slave (
        output U_in, Z_in, q_I, q_Opening, q_Bad,
        input  U, Z, Timerout, lock_clr, Lockout, fail_cnt
    );
endinterface

// File: rtl/ee201_numlock_ctrl.sv
// ee201_numlock_ctrl: gates buttons into the ee201 lock, times Opening, counts failures, enforces lockout, clears stalled entries
// Ports:
//   Clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    ee201_numlock_ctrl_if.master (buttons and lock status in; U, Z, Timerout, lock_clr, Lockout, fail_cnt out)
// Optional: define NUMLOCK_BACKOFF_EN to double the lockout length on each successive lockout (up to 8x);
// an Opening clears the backoff level.
module ee201_numlock_ctrl #(
    parameter int OPEN_CYCLES    = 5,
    parameter int IDLE_TO        = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 2000,
    parameter int CNT_W          = 16,
    parameter int FAIL_W         = 2
) (
    input logic Clk,
    input logic reset,
    ee201_numlock_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_ARM, S_CONFLICT, S_OPEN, S_LOCKOUT} state_t;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              q_Opening_d;
    logic              q_Bad_d;
    logic              open_rise;
    logic              bad_rise;
    logic [FAIL_W-1:0] fail_inc;
    logic              fail_trip;
    logic [CNT_W-1:0]  lock_last;
    assign open_rise = bus.q_Opening & ~q_Opening_d;
    assign bad_rise  = bus.q_Bad & ~q_Bad_d;
    assign fail_inc  = &bus.fail_cnt ? bus.fail_cnt : bus.fail_cnt + FAIL_W'(1);
    assign fail_trip = fail_inc >= FAIL_W'(MAX_FAILS);
`ifdef NUMLOCK_BACKOFF_EN
    logic [1:0] lockout_level;
    assign lock_last = (CNT_W'(LOCKOUT_CYCLES) << lockout_level) - CNT_W'(1);
`else
    assign lock_last = CNT_W'(LOCKOUT_CYCLES - 1);
`endif
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state        <= S_ARM;
            cnt          <= '0;
            q_Opening_d  <= 1'b0;
            q_Bad_d      <= 1'b0;
            bus.U        <= 1'b0;
            bus.Z        <= 1'b0;
            bus.Timerout <= 1'b0;
            bus.lock_clr <= 1'b0;
            bus.Lockout  <= 1'b0;
            bus.fail_cnt <= '0;
`ifdef NUMLOCK_BACKOFF_EN
            lockout_level <= 2'd0;
`endif
        end else begin
            q_Opening_d  <= bus.q_Opening;
            q_Bad_d      <= bus.q_Bad;
            bus.Timerout <= 1'b0;
            bus.lock_clr <= 1'b0;
            // A successful open outranks everything except an active lockout.
            if (state != S_LOCKOUT && open_rise) begin
                state        <= S_OPEN;
                cnt          <= '0;
                bus.fail_cnt <= '0;
                bus.U        <= 1'b0;
                bus.Z        <= 1'b0;
`ifdef NUMLOCK_BACKOFF_EN
                lockout_level <= 2'd0;
`endif
            end else if ((state == S_ARM || state == S_CONFLICT) && bad_rise && fail_trip) begin
                state        <= S_LOCKOUT;
                cnt          <= '0;
                bus.fail_cnt <= fail_inc;
                bus.Lockout  <= 1'b1;
                bus.U        <= 1'b0;
                bus.Z        <= 1'b0;
            end else begin
                case (state)
                    S_ARM: begin
                        bus.U <= bus.U_in & ~bus.Z_in;
                        bus.Z <= bus.Z_in & ~bus.U_in;
                        if (bad_rise) bus.fail_cnt <= fail_inc;
                        if (bus.U_in & bus.Z_in) state <= S_CONFLICT;
                        // Inactivity: any button, a failure or the lock sitting in I restarts the count.
                        if (bus.q_I | bus.U_in | bus.Z_in | bad_rise) begin
                            cnt <= '0;
                        end else if (cnt == CNT_W'(IDLE_TO - 1)) begin
                            bus.lock_clr <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_CONFLICT: begin
                        bus.U <= 1'b0;
                        bus.Z <= 1'b0;
                        cnt   <= '0;
                        if (bad_rise) bus.fail_cnt <= fail_inc;
                        if (!bus.U_in && !bus.Z_in) state <= S_ARM;
                    end
                    S_OPEN: begin
                        bus.U <= 1'b0;
                        bus.Z <= 1'b0;
                        cnt   <= cnt + CNT_W'(1);
                        if (!bus.q_Opening) begin
                            state <= S_ARM;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(OPEN_CYCLES - 1)) begin
                            bus.Timerout <= 1'b1;
                            state        <= S_ARM;
                            cnt          <= '0;
                        end
                    end
                    S_LOCKOUT: begin
                        bus.U <= 1'b0;
                        bus.Z <= 1'b0;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == lock_last) begin
                            // A button still held at exit must be released before it reaches the lock.
                            state        <= (bus.U_in | bus.Z_in) ? S_CONFLICT : S_ARM;
                            cnt          <= '0;
                            bus.fail_cnt <= '0;
                            bus.lock_clr <= 1'b1;
                            bus.Lockout  <= 1'b0;
`ifdef NUMLOCK_BACKOFF_EN
                            lockout_level <= lockout_level + {1'b0, ~&lockout_level};
`endif
                        end
                    end
                    default: state <= S_ARM;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ee201_numlock_ctrl.sv
// tb_ee201_numlock_ctrl: directed scoreboard bench for ee201_numlock_ctrl
module tb_ee201_numlock_ctrl;
    // Input vectors {U_in, Z_in, q_I, q_Opening, q_Bad}
    localparam logic [4:0] IDLE_I = 5'b00100;
    localparam logic [4:0] U_I    = 5'b10100;
    localparam logic [4:0] UZ_I   = 5'b11100;
    localparam logic [4:0] BAD_I  = 5'b00101;
    localparam logic [4:0] IDLE_N = 5'b00000;
    localparam logic [4:0] U_N    = 5'b10000;
    localparam logic [4:0] Z_N    = 5'b01000;
    localparam logic [4:0] OPEN   = 5'b00010;
    localparam logic [4:0] OPEN_U = 5'b10010;
    localparam logic [4:0] OP_BAD = 5'b00011;
    localparam logic [4:0] BAD_N  = 5'b00001;
    // Expected vectors {U, Z, Timerout, lock_clr, Lockout, fail_cnt[1:0]}
    localparam logic [6:0] O_0  = 7'b0000000;
    localparam logic [6:0] O_U  = 7'b1000000;
    localparam logic [6:0] O_Z  = 7'b0100000;
    localparam logic [6:0] O_T  = 7'b0010000;
    localparam logic [6:0] O_C  = 7'b0001000;
    localparam logic [6:0] O_L3 = 7'b0000111;
    localparam logic [6:0] O_F1 = 7'b0000001;
    localparam logic [6:0] O_F2 = 7'b0000010;

    logic Clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    string tag_q[$];

    ee201_numlock_ctrl_if #(.FAIL_W(2)) bus ();

    ee201_numlock_ctrl #(
        .OPEN_CYCLES(5),
        .IDLE_TO(1000),
        .MAX_FAILS(3),
        .LOCKOUT_CYCLES(2000),
        .CNT_W(16),
        .FAIL_W(2)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic push(input string t, input logic [6:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        logic [6:0] e;
        logic [6:0] o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {bus.U, bus.Z, bus.Timerout, bus.lock_clr, bus.Lockout, bus.fail_cnt};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        {bus.U_in, bus.Z_in, bus.q_I, bus.q_Opening, bus.q_Bad} = v;
    endtask

    task automatic cyc(input logic [4:0] v, input logic [6:0] e, input string t);
        drive(v);
        push(t, e);
        @(posedge Clk);
        #1;
        pop_check();
    endtask

    task automatic enter_lockout();
        cyc(BAD_I, O_F1, "bad1");
        cyc(IDLE_I, O_F1, "bad1_rel");
        cyc(BAD_I, O_F2, "bad2");
        cyc(IDLE_I, O_F2, "bad2_rel");
        cyc(BAD_I, O_L3, "bad3_lockout");
    endtask

    task automatic lockout_run(input int len, input bit hold);
        for (int i = 1; i < len; i++) begin
            logic [4:0] v;
            v = (i < len - 3) ? {2'($urandom_range(0, 3)), 3'b100} : (hold ? U_I : IDLE_I);
            cyc(v, O_L3, "lockout_active");
        end
        cyc(hold ? U_I : IDLE_I, O_C, "lockout_exit");
    endtask

    initial begin
        drive(IDLE_I);
        repeat (2) @(posedge Clk);
        #1;
        push("reset_state", O_0);
        pop_check();
        reset = 1'b1;
        cyc(IDLE_I, O_0, "post_reset");
        // Correct entry U Z U U, then Opening
        cyc(U_I, O_U, "entry_u1");
        cyc(IDLE_N, O_0, "entry_rel1");
        cyc(Z_N, O_Z, "entry_z");
        cyc(IDLE_N, O_0, "entry_rel2");
        cyc(U_N, O_U, "entry_u2");
        cyc(IDLE_N, O_0, "entry_rel3");
        cyc(U_N, O_U, "entry_u3");
        cyc(IDLE_N, O_0, "entry_rel4");
        cyc(OPEN, O_0, "open_rise");
        cyc(OPEN, O_0, "open_c1");
        cyc(OPEN_U, O_0, "open_u_blocked");
        cyc(OPEN, O_0, "open_c3");
        cyc(OPEN, O_0, "open_c4");
        cyc(OPEN, O_T, "timerout");
        cyc(IDLE_I, O_0, "timerout_end");
        // Simultaneous press
        repeat (3) cyc(UZ_I, O_0, "conf_both");
        repeat (2) cyc(U_I, O_0, "conf_u_only");
        cyc(IDLE_I, O_0, "conf_release");
        cyc(U_I, O_U, "conf_u_pass");
        cyc(IDLE_I, O_0, "conf_u_rel");
        // open_rise beats bad_rise, then early drop of Opening
        cyc(BAD_I, O_F1, "pri_bad1");
        cyc(IDLE_I, O_F1, "pri_bad1_rel");
        cyc(BAD_I, O_F2, "pri_bad2");
        cyc(IDLE_I, O_F2, "pri_bad2_rel");
        cyc(OP_BAD, O_0, "pri_open_over_bad");
        cyc(BAD_N, O_0, "early_drop");
        repeat (6) cyc(IDLE_I, O_0, "no_timerout");
        // Lockout with clean exit
        enter_lockout();
        lockout_run(2000, 1'b0);
        cyc(U_I, O_U, "post_lockout_u");
        cyc(IDLE_I, O_0, "post_lockout_rel");
        // Lockout with a button held at exit
        enter_lockout();
`ifdef NUMLOCK_BACKOFF_EN
        lockout_run(4000, 1'b1);
`else
        lockout_run(2000, 1'b1);
`endif
        cyc(U_I, O_0, "held_wait");
        cyc(IDLE_I, O_0, "held_release");
        cyc(U_I, O_U, "held_u_pass");
        cyc(IDLE_I, O_0, "held_u_rel");
`ifdef NUMLOCK_BACKOFF_EN
        cyc(OPEN, O_0, "bo_open");
        cyc(IDLE_I, O_0, "bo_close");
        enter_lockout();
        lockout_run(2000, 1'b0);
`endif
        // Inactivity timeout
        cyc(IDLE_I, O_0, "idle_arm");
        for (int i = 1; i < 1000; i++) cyc(IDLE_N, O_0, "idle_wait");
        cyc(IDLE_N, O_C, "idle_timeout");
        cyc(IDLE_N, O_0, "idle_pulse_end");
        cyc(IDLE_I, O_0, "idle_rearm");
        for (int i = 1; i < 999; i++) cyc(IDLE_N, O_0, "idle_wait2");
        cyc(U_N, O_U, "idle_press_999");
        cyc(IDLE_N, O_0, "idle_1000_no_pulse");
        for (int i = 2; i < 1000; i++) cyc(IDLE_N, O_0, "idle_restart_wait");
        cyc(IDLE_N, O_C, "idle_restart_timeout");
        cyc(IDLE_I, O_0, "idle_done");
        // Async reset mid-lockout
        enter_lockout();
        for (int i = 1; i < 500; i++) cyc(IDLE_I, O_L3, "lockout_pre_reset");
        #2;
        reset = 1'b0;
        #1;
        push("reset_async", O_0);
        pop_check();
        @(posedge Clk);
        #1;
        push("reset_hold", O_0);
        pop_check();
        reset = 1'b1;
        cyc(IDLE_I, O_0, "reset_release_nopulse");
        cyc(U_I, O_U, "reset_u_latency");
        cyc(IDLE_I, O_0, "reset_u_rel");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
